// File: rtl/display_bcd_scheduler.sv
// Shared shift-add-3 binary-to-BCD converter, time-multiplexed between OUT, IN and PC display
// requesters with fixed priority OUT > IN > PC.
module display_bcd_scheduler #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  out_req,
    input  logic [WIDTH-1:0]      out_data,
    output logic                  out_ack,
    input  logic                  in_req,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ack,
    input  logic [WIDTH-1:0]      pc_value,
    output logic                  busy,
    output logic [WIDTH-1:0]      saida,
    output logic [4*DIGITS-1:0]   segmentos,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   segmentosPrograma
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 2);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    typedef enum logic [1:0] {SRC_OUT, SRC_IN, SRC_PC} src_t;

    state_t           state;
    src_t             src;
    logic [WIDTH-2:0] mag;
    logic             neg_n;
    logic [WIDTH-1:0] operand;
    logic [BW-1:0]    bcd;
    logic [CW-1:0]    cnt;

    logic [BW-1:0]    bcd_adj;
    logic [BW-1:0]    bcd_next;
    logic [WIDTH-1:0] out_abs;

    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        // mag is shifted left each cycle, so its MSB is always bit WIDTH-2-cnt of the original
        bcd_next = {bcd_adj[BW-2:0], mag[WIDTH-2]};
        out_abs  = out_data[WIDTH-1] ? (~out_data + WIDTH'(1)) : out_data;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            src               <= SRC_PC;
            mag               <= '0;
            neg_n             <= 1'b0;
            operand           <= '0;
            bcd               <= '0;
            cnt               <= '0;
            out_ack           <= 1'b0;
            in_ack            <= 1'b0;
            saida             <= '0;
            segmentos         <= '0;
            neg               <= 1'b0;
            segmentosPrograma <= '0;
        end else begin
            out_ack <= 1'b0;
            in_ack  <= 1'b0;
            case (state)
                IDLE: begin
                    bcd   <= '0;
                    cnt   <= '0;
                    state <= CONV;
                    if (out_req) begin
                        src     <= SRC_OUT;
                        mag     <= out_abs[WIDTH-2:0];
                        neg_n   <= out_data[WIDTH-1];
                        operand <= out_data;
                    end else if (in_req) begin
                        src     <= SRC_IN;
                        mag     <= in_data[WIDTH-2:0];
                        neg_n   <= 1'b0;
                        operand <= in_data;
                    end else begin
                        src     <= SRC_PC;
                        mag     <= pc_value[WIDTH-2:0];
                        neg_n   <= 1'b0;
                        operand <= pc_value;
                    end
                end
                CONV: begin
                    bcd <= bcd_next;
                    mag <= mag << 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                        case (src)
                            SRC_OUT: begin
                                segmentos <= bcd_next;
                                saida     <= operand;
                                neg       <= neg_n;
                                out_ack   <= 1'b1;
                            end
                            SRC_IN: begin
                                segmentos <= bcd_next;
                                saida     <= operand;
                                neg       <= 1'b0;
                                in_ack    <= 1'b1;
                            end
                            default: segmentosPrograma <= bcd_next;
                        endcase
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_bcd_scheduler.sv
// Scoreboard bench for display_bcd_scheduler: the driver queues expected commits, a monitor
// checks each out_ack/in_ack pulse against the queue head.
module tb_display_bcd_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        out_req, in_req;
    logic [31:0] out_data, in_data, pc_value;
    logic        out_ack, in_ack, busy, neg;
    logic [31:0] saida, segmentos, segmentosPrograma;

    typedef struct {
        logic        is_out;
        logic [31:0] seg;
        logic [31:0] raw;
        logic        sgn;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    display_bcd_scheduler #(.WIDTH(32), .DIGITS(8)) dut (
        .clock(clock), .reset(reset),
        .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
        .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
        .pc_value(pc_value), .busy(busy), .saida(saida),
        .segmentos(segmentos), .neg(neg), .segmentosPrograma(segmentosPrograma)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every ack pulse must match the oldest queued expectation.
    initial begin
        logic prev_ack;
        exp_t e;
        prev_ack = 1'b0;
        forever begin
            @(negedge clock);
            if (out_ack || in_ack) begin
                check("ack_single_cycle", {31'b0, prev_ack}, 32'd0);
                check("ack_exclusive", {31'b0, out_ack & in_ack}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_ack: out_ack=%0b in_ack=%0b with empty queue", out_ack, in_ack);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_source", {31'b0, out_ack}, {31'b0, e.is_out});
                    check("segmentos", segmentos, e.seg);
                    check("saida", saida, e.raw);
                    check("neg", {31'b0, neg}, {31'b0, e.sgn});
                end
            end
            prev_ack = out_ack | in_ack;
        end
    end

    // Bounded wait for the requested ack; drops the request in the ack cycle.
    task automatic wait_ack(input logic is_out);
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if (is_out ? out_ack : in_ack) begin
                if (is_out) out_req = 1'b0; else in_req = 1'b0;
                return;
            end
        end
        checks++;
        fails++;
        $display("FAIL ack_timeout: is_out=%0b no ack within 200 cycles", is_out);
        if (is_out) out_req = 1'b0; else in_req = 1'b0;
    endtask

    task automatic issue(input logic is_out, input logic [31:0] data,
                         input logic [31:0] seg, input logic sgn);
        exp_q.push_back('{is_out, seg, data, sgn});
        @(negedge clock);
        if (is_out) begin out_data = data; out_req = 1'b1; end
        else        begin in_data  = data; in_req  = 1'b1; end
        wait_ack(is_out);
    endtask

    initial begin
        reset = 1'b1; out_req = 1'b0; in_req = 1'b0;
        out_data = '0; in_data = '0; pc_value = 32'd42;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_segmentos", segmentos, 32'h0);
        check("rst_saida", saida, 32'h0);
        check("rst_neg", {31'b0, neg}, 32'd0);
        check("rst_segprog", segmentosPrograma, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_acks", {30'b0, out_ack, in_ack}, 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1 check("pc_start_busy", {31'b0, busy}, 32'd1);

        repeat (70) @(negedge clock);
        check("pc_42", segmentosPrograma, 32'h00000042);
        check("pc_no_disturb_seg", segmentos, 32'h0);

        issue(1'b1, 32'd12345,      32'h00012345, 1'b0);
        issue(1'b1, 32'hFFFFFFFF,   32'h00000001, 1'b1);
        issue(1'b1, 32'h80000000,   32'h00000000, 1'b1);
        issue(1'b1, 32'hFFFFCFC7,   32'h00012345, 1'b1);
        issue(1'b1, 32'h7FFFFFFF,   32'h47483647, 1'b0);
        issue(1'b0, 32'd123456789,  32'h23456789, 1'b0);
        issue(1'b0, 32'h80000005,   32'h00000005, 1'b0);

        // Simultaneous OUT and IN: OUT must commit first.
        exp_q.push_back('{1'b1, 32'h00000007, 32'hFFFFFFF9, 1'b1});
        exp_q.push_back('{1'b0, 32'h00000099, 32'd99, 1'b0});
        @(negedge clock);
        out_data = 32'hFFFFFFF9; in_data = 32'd99;
        out_req = 1'b1; in_req = 1'b1;
        wait_ack(1'b1);
        wait_ack(1'b0);

        pc_value = 32'd99999999;
        repeat (80) @(negedge clock);
        check("pc_99999999", segmentosPrograma, 32'h99999999);
        check("pc_keep_seg", segmentos, 32'h00000099);
        check("pc_keep_saida", saida, 32'd99);

        // Reset in the middle of an OUT conversion.
        issue(1'b1, 32'd777, 32'h00000777, 1'b0);
        @(negedge clock);
        check("idle_after_done", {31'b0, busy}, 32'd0);
        out_data = 32'd4321; out_req = 1'b1;
        repeat (16) @(negedge clock);
        check("conv_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1; out_req = 1'b0;
        @(negedge clock);
        check("mid_rst_segmentos", segmentos, 32'h0);
        check("mid_rst_saida", saida, 32'h0);
        check("mid_rst_neg", {31'b0, neg}, 32'd0);
        check("mid_rst_segprog", segmentosPrograma, 32'h0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        repeat (70) @(negedge clock);
        check("post_rst_pc", segmentosPrograma, 32'h99999999);
        check("post_rst_seg", segmentos, 32'h0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
